pc_next_unit: RTL and testbench

- Program-counter register and next-PC selector for the single-issue fetch stage.
- Consumes the 32-bit jump address produced by the jump-address concat stage (upper 4 bits of PC+4 joined with the 28-bit shifted target).
- Supplies pc_plus4[31:28] back to that stage.
- Drives the instruction-fetch address with a valid/ready handshake, stall support and a one-deep pending-redirect buffer.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/branch_target_calc.sv | 15 +
 rtl/pc_next_unit.sv | 99 +++++++++
 tb/tb_pc_next_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch/decode types: address type, PC step constants and the PC FSM states.
package cpu_pkg;

  typedef logic [31:0] addr_t;

  localparam addr_t PC_STEP          = 32'd4;
  localparam addr_t RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pc_state_t;

endpackage

// File: rtl/branch_target_calc.sv
// Branch target adder: pc+4 plus a sign-extended word offset, modulo 2^32.
module branch_target_calc
  import cpu_pkg::*;
(
  input  addr_t       i_pc_plus4,
  input  logic [15:0] i_imm,
  output addr_t       o_target
);

  addr_t w_offset;

  assign w_offset = {{14{i_imm[15]}}, i_imm, 2'b00};
  assign o_target = i_pc_plus4 + w_offset;

endmodule

// File: rtl/pc_next_unit.sv
// Program counter and next-PC selection for the fetch stage, with a boot delay,
// stall handling and a one-deep buffer for redirects that arrive while stalled.
module pc_next_unit
  import cpu_pkg::*;
#(
  parameter addr_t RESET_PC   = RESET_PC_DEFAULT,
  parameter int    BOOT_DELAY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch,
  input  logic [15:0] branch_imm,
  input  logic        stall,
  input  logic        fetch_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        redirect,
  output logic        pending
);

  pc_state_t  r_state, w_state_nxt;
  logic [3:0] r_boot_cnt, w_boot_cnt_nxt;
  addr_t      r_pc, r_pend_target;
  addr_t      w_br_target, w_jump_target, w_target;
  logic       r_pending, r_redirect;
  logic       w_adv, w_req;

  assign pc_plus4 = r_pc + PC_STEP;

  branch_target_calc u_btc (
    .i_pc_plus4 (pc_plus4),
    .i_imm      (branch_imm),
    .o_target   (w_br_target)
  );

  assign w_jump_target = jump_target & ~32'h0000_0003;
  assign w_target      = jump ? w_jump_target : w_br_target;

  assign fetch_valid = (r_state == RUN);
  // Requests only exist in RUN; during boot they are dropped on the floor.
  assign w_req       = fetch_valid & (jump | branch);
  assign w_adv       = fetch_valid & fetch_ready & ~stall;

  always_comb begin
    w_state_nxt    = r_state;
    w_boot_cnt_nxt = r_boot_cnt;
    if (r_state == BOOT) begin
      if (r_boot_cnt == 4'(BOOT_DELAY)) w_state_nxt = RUN;
      else                              w_boot_cnt_nxt = r_boot_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= BOOT;
      r_boot_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_boot_cnt <= w_boot_cnt_nxt;
    end
  end

  // A buffered redirect is older than anything on the inputs, so it wins on advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_pending  <= 1'b0;
      r_redirect <= 1'b0;
    end else begin
      r_redirect <= 1'b0;
      if (w_adv) begin
        if (r_pending) begin
          r_pc       <= r_pend_target;
          r_pending  <= 1'b0;
          r_redirect <= 1'b1;
        end else if (w_req) begin
          r_pc       <= w_target;
          r_redirect <= 1'b1;
        end else begin
          r_pc <= pc_plus4;
        end
      end else if (w_req) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!w_adv && w_req) r_pend_target <= w_target;
  end

  assign pc       = r_pc;
  assign redirect = r_redirect;
  assign pending  = r_pending;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: boot, sequential fetch, jumps, branches,
// stall buffering, address wrap and reset while a redirect is pending.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump;
  logic [31:0] jump_target;
  logic        branch;
  logic [15:0] branch_imm;
  logic        stall;
  logic        fetch_ready;

  logic [31:0] pc, pc_plus4;
  logic        fetch_valid, redirect, pending;
  logic [31:0] pc2, pc_plus4_2;
  logic        fetch_valid2, redirect2, pending2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_next_unit #(.RESET_PC(32'h0000_0000), .BOOT_DELAY(2)) dut (
    .clk(clk), .rst_n(rst_n), .jump(jump), .jump_target(jump_target),
    .branch(branch), .branch_imm(branch_imm), .stall(stall),
    .fetch_ready(fetch_ready), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .redirect(redirect), .pending(pending)
  );

  pc_next_unit #(.RESET_PC(32'hFFFF_FFF8), .BOOT_DELAY(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .jump(jump), .jump_target(jump_target),
    .branch(branch), .branch_imm(branch_imm), .stall(stall),
    .fetch_ready(fetch_ready), .pc(pc2), .pc_plus4(pc_plus4_2),
    .fetch_valid(fetch_valid2), .redirect(redirect2), .pending(pending2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; jump = 1'b0; jump_target = '0; branch = 1'b0;
    branch_imm = '0; stall = 1'b0; fetch_ready = 1'b1;
    tick(); tick();
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL reset_fv got=%b exp=0", fetch_valid); end
    total++; if (redirect !== 1'b0) begin bad++; $display("FAIL reset_redirect got=%b exp=0", redirect); end
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%b exp=0", pending); end
    total++; if (pc2 !== 32'hFFFF_FFF8) begin bad++; $display("FAIL reset_pc2 got=%h exp=%h", pc2, 32'hFFFF_FFF8); end
    total++; if (fetch_valid2 !== 1'b0) begin bad++; $display("FAIL reset_fv2 got=%b exp=0", fetch_valid2); end
  endtask

  task automatic test_boot_and_wrap();
    logic [31:0] exp_seq [4];
    exp_seq[0] = 32'h0; exp_seq[1] = 32'h4; exp_seq[2] = 32'h8; exp_seq[3] = 32'hC;
    rst_n = 1'b1;
    tick();
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL boot_fv1 got=%b exp=0", fetch_valid); end
    total++; if (fetch_valid2 !== 1'b1) begin bad++; $display("FAIL boot0_fv got=%b exp=1", fetch_valid2); end
    total++; if (pc2 !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_pc0 got=%h exp=%h", pc2, 32'hFFFF_FFF8); end
    tick();
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL boot_fv2 got=%b exp=0", fetch_valid); end
    total++; if (pc2 !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc1 got=%h exp=%h", pc2, 32'hFFFF_FFFC); end
    total++; if (pc_plus4_2 !== 32'h0) begin bad++; $display("FAIL wrap_plus4 got=%h exp=%h", pc_plus4_2, 32'h0); end
    tick();
    total++; if (pc2 !== 32'h0) begin bad++; $display("FAIL wrap_pc2 got=%h exp=%h", pc2, 32'h0); end
    for (int i = 0; i < 4; i++) begin
      total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL seq_fv[%0d] got=%b exp=1", i, fetch_valid); end
      total++; if (pc !== exp_seq[i]) begin bad++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc, exp_seq[i]); end
      if (i < 3) tick();
    end
  endtask

  task automatic test_jump();
    jump = 1'b1; jump_target = 32'h3000_0002;
    tick();
    total++; if (pc !== 32'h3000_0000) begin bad++; $display("FAIL jump_lowbits got=%h exp=%h", pc, 32'h3000_0000); end
    total++; if (pc_plus4[31:28] !== 4'h3) begin bad++; $display("FAIL plus4_hi got=%h exp=3", pc_plus4[31:28]); end
    jump_target = {4'h3, 28'h000_0100};
    tick();
    total++; if (pc !== 32'h3000_0100) begin bad++; $display("FAIL jump_pc got=%h exp=%h", pc, 32'h3000_0100); end
    total++; if (redirect !== 1'b1) begin bad++; $display("FAIL jump_redirect got=%b exp=1", redirect); end
    jump = 1'b0;
    tick();
    total++; if (pc !== 32'h3000_0104) begin bad++; $display("FAIL jump_seq got=%h exp=%h", pc, 32'h3000_0104); end
    total++; if (redirect !== 1'b0) begin bad++; $display("FAIL jump_pulse got=%b exp=0", redirect); end
  endtask

  task automatic test_branch();
    jump = 1'b1; jump_target = 32'h40;
    tick();
    jump = 1'b0; branch = 1'b1; branch_imm = 16'hFFFE;
    tick();
    total++; if (pc !== 32'h3C) begin bad++; $display("FAIL branch_neg got=%h exp=%h", pc, 32'h3C); end
    total++; if (redirect !== 1'b1) begin bad++; $display("FAIL branch_redirect got=%b exp=1", redirect); end
    jump = 1'b1; jump_target = 32'h200; branch_imm = 16'h0010;
    tick();
    total++; if (pc !== 32'h200) begin bad++; $display("FAIL jump_priority got=%h exp=%h", pc, 32'h200); end
    jump = 1'b0; branch_imm = 16'h8000;
    tick();
    total++; if (pc !== 32'hFFFE_0204) begin bad++; $display("FAIL branch_minimm got=%h exp=%h", pc, 32'hFFFE_0204); end
    branch = 1'b0;
  endtask

  task automatic test_stall_pending();
    jump = 1'b1; jump_target = 32'h100;
    tick();
    jump = 1'b0; stall = 1'b1; branch = 1'b1; branch_imm = 16'h0004;
    tick();
    total++; if (pc !== 32'h100) begin bad++; $display("FAIL stall_hold got=%h exp=%h", pc, 32'h100); end
    total++; if (pending !== 1'b1) begin bad++; $display("FAIL stall_pending got=%b exp=1", pending); end
    total++; if (redirect !== 1'b0) begin bad++; $display("FAIL stall_redirect got=%b exp=0", redirect); end
    branch = 1'b0;
    tick(); tick();
    total++; if (pc !== 32'h100) begin bad++; $display("FAIL stall_hold3 got=%h exp=%h", pc, 32'h100); end
    total++; if (pending !== 1'b1) begin bad++; $display("FAIL stall_pending3 got=%b exp=1", pending); end
    stall = 1'b0;
    tick();
    total++; if (pc !== 32'h114) begin bad++; $display("FAIL pend_apply got=%h exp=%h", pc, 32'h114); end
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL pend_clear got=%b exp=0", pending); end
    total++; if (redirect !== 1'b1) begin bad++; $display("FAIL pend_redirect got=%b exp=1", redirect); end
    tick();
    fetch_ready = 1'b0;
    tick();
    total++; if (pc !== 32'h118) begin bad++; $display("FAIL notready_hold got=%h exp=%h", pc, 32'h118); end
    fetch_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    stall = 1'b1; jump = 1'b1; jump_target = 32'h500;
    tick();
    jump = 1'b0; branch = 1'b1; branch_imm = 16'h0001;
    tick();
    stall = 1'b0; branch = 1'b0;
    tick();
    total++; if (pc !== 32'h120) begin bad++; $display("FAIL pend_overwrite got=%h exp=%h", pc, 32'h120); end
    stall = 1'b1; jump = 1'b1; jump_target = 32'h600;
    tick();
    stall = 1'b0; jump_target = 32'h700;
    tick();
    total++; if (pc !== 32'h600) begin bad++; $display("FAIL pend_older_wins got=%h exp=%h", pc, 32'h600); end
    jump = 1'b0;
    tick();
    total++; if (pc !== 32'h604) begin bad++; $display("FAIL pend_newer_dropped got=%h exp=%h", pc, 32'h604); end
  endtask

  task automatic test_reset_pending();
    stall = 1'b1; jump = 1'b1; jump_target = 32'h900;
    tick();
    total++; if (pending !== 1'b1) begin bad++; $display("FAIL rp_setup got=%b exp=1", pending); end
    jump = 1'b0; stall = 1'b0; rst_n = 1'b0;
    tick();
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL rp_pc got=%h exp=%h", pc, 32'h0); end
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL rp_pending got=%b exp=0", pending); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL rp_fv got=%b exp=0", fetch_valid); end
    rst_n = 1'b1; jump = 1'b1; jump_target = 32'hA00;
    tick();
    jump = 1'b0;
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL boot_ignores_req got=%b exp=0", pending); end
    tick(); tick();
    total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL rp_boot_fv got=%b exp=1", fetch_valid); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL rp_first got=%h exp=%h", pc, 32'h0); end
    tick();
    total++; if (pc !== 32'h4) begin bad++; $display("FAIL rp_second got=%h exp=%h", pc, 32'h4); end
    tick();
    total++; if (pc !== 32'h8) begin bad++; $display("FAIL rp_third got=%h exp=%h", pc, 32'h8); end
  endtask

  initial begin
    test_reset();
    test_boot_and_wrap();
    test_jump();
    test_branch();
    test_stall_pending();
    test_back_to_back();
    test_reset_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
